// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector write packer.
//
// Purpose : lane/word/vector/address widths, the pending-slot state
//           encoding and a helper that assembles a vector from lane words
//           with invalid lanes forced to zero.
// Ports   : none (package).
package vec_mem_pkg;

    localparam int LANES  = 8;
    localparam int WORD_W = 32;
    localparam int VEC_W  = 256;
    localparam int ADDR_W = 16;
    localparam int LANE_W = $clog2(LANES);

    // Pending slot: EMPTY (nothing held), PEND (holding a packed line,
    // competing with the pipeline), FORCE (starved; wins next cycle).
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_FORCE = 2'd2
    } slot_state_t;

    // Lane k lands in bits [32k+31:32k]; lanes whose mask bit is clear are
    // written as zero so stale accumulator contents never reach the RAM.
    function automatic logic [VEC_W-1:0] pack_lanes(
        input logic [LANES-1:0][WORD_W-1:0] words,
        input logic [LANES-1:0]             mask
    );
        logic [VEC_W-1:0] vec;
        vec = '0;
        for (int k = 0; k < LANES; k++) begin
            if (mask[k]) begin
                vec[k*WORD_W +: WORD_W] = words[k];
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/vec_lane_acc.sv
// Scalar-to-vector lane accumulator.
//
// Purpose : collects 32-bit scalar writes into one 8-lane vector line,
//           tracks per-lane valid bits and decides when the line must move
//           to the arbiter's pending slot (line full, address change, flush).
// Ports   :
//   clk, rst_n            clock, asynchronous active-low reset
//   s_we, s_addr, s_data  scalar write stream (word address)
//   flush                 push any valid lanes out as a partial line
//   slot_free             pending slot can take a line this cycle
//                         (empty, or being drained in this same cycle)
//   s_stall               scalar write refused this cycle
//   move                  line handed to the pending slot this cycle
//   move_addr, move_data  vector address and zero-filled line being moved
//   acc_busy              at least one lane valid
module vec_lane_acc
    import vec_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [WORD_W-1:0] s_data,
    input  logic              flush,
    input  logic              slot_free,
    output logic              s_stall,
    output logic              move,
    output logic [ADDR_W-1:0] move_addr,
    output logic [VEC_W-1:0]  move_data,
    output logic              acc_busy
);

    logic [LANES-1:0][WORD_W-1:0] data_q;
    logic [LANES-1:0][WORD_W-1:0] merged_data;
    logic [LANES-1:0]             valid_q;
    logic [LANES-1:0]             merged_valid;
    logic [LANES-1:0]             lane_bit;
    logic [ADDR_W-1:0]            addr_q;
    logic [ADDR_W-1:0]            wr_vaddr;
    logic [ADDR_W-1:0]            line_addr;
    logic [LANE_W-1:0]            wr_lane;
    logic                         acc_empty;
    logic                         addr_hit;
    logic                         merge_wr;
    logic                         addr_change;
    logic                         move_req;
    logic                         accept;

    assign wr_lane  = s_addr[LANE_W-1:0];
    assign wr_vaddr = s_addr >> LANE_W;

    // The "merged" view is the line as it would look with this cycle's write
    // folded in. On an address change the write does not merge, so the
    // merged view is just the old line -- which is exactly what must move.
    // That lets one datapath serve every move reason, and makes a flush
    // coincident with a write carry the new word out with the line.
    always_comb begin
        acc_empty    = (valid_q == '0);
        addr_hit     = acc_empty || (wr_vaddr == addr_q);
        merge_wr     = s_we && addr_hit;
        addr_change  = s_we && !addr_hit;
        lane_bit     = '0;
        lane_bit[wr_lane] = 1'b1;
        merged_valid = valid_q;
        merged_data  = data_q;
        if (merge_wr) begin
            merged_valid          = valid_q | lane_bit;
            merged_data[wr_lane]  = s_data;
        end
        line_addr = acc_empty ? wr_vaddr : addr_q;
        move_req  = addr_change
                 || (merged_valid == '1)
                 || (flush && (merged_valid != '0));
        // A move that cannot land stalls a write outright (nothing is
        // applied). A flush without a write simply waits: flush is a level
        // and takes effect on the first cycle the slot can accept.
        s_stall   = s_we && move_req && !slot_free;
        move      = move_req && slot_free;
        accept    = s_we && !s_stall;
    end

    assign move_addr = line_addr;
    assign move_data = pack_lanes(merged_data, merged_valid);
    assign acc_busy  = !acc_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else if (move) begin
            if (addr_change) begin
                // Old line leaves; the new word starts a fresh line.
                valid_q          <= lane_bit;
                data_q[wr_lane]  <= s_data;
                addr_q           <= wr_vaddr;
            end else begin
                valid_q <= '0;
            end
        end else if (accept) begin
            valid_q <= merged_valid;
            data_q  <= merged_data;
            addr_q  <= line_addr;
        end
    end

endmodule

// File: rtl/vec_pack_arbiter.sv
// Vector RAM write port shared between the pipeline and a scalar packer.
//
// Purpose : scalar word writes are packed into 8-lane vector lines by
//           vec_lane_acc; completed lines wait in a one-entry pending slot
//           and compete with pipeline vector writes for the RAM port. The
//           pipeline normally wins; a line that loses STARVE_MAX times is
//           forced through on the next cycle.
// Ports   :
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_we, s_addr, s_data       scalar write stream; s_stall refuses a write
//   flush                      push a partial line to the pending slot
//   v_we, v_addr, v_wdata      pipeline vector write; v_stall refuses it
//   ram_we, ram_addr, ram_wdata registered RAM write port
//   busy                       accumulator or pending slot holds data
//
// Handshake: a request (s_we / v_we) is taken on a rising edge when its
// stall output is low in that cycle; while stall is high the requester
// keeps the same request asserted and unchanged. Stalls are combinational
// and never depend on the requester's own data.
//
// STARVE_MAX must be at least 1.
module vec_pack_arbiter
    import vec_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_stall,
    input  logic              flush,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [VEC_W-1:0]  v_wdata,
    output logic              v_stall,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [VEC_W-1:0]  ram_wdata,
    output logic              busy
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

    slot_state_t        slot_q;
    logic [CNT_W-1:0]   wait_q;
    logic [CNT_W-1:0]   wait_next;
    logic [ADDR_W-1:0]  pend_addr_q;
    logic [VEC_W-1:0]   pend_data_q;
    logic               grant_pipe;
    logic               grant_pack;
    logic               slot_free;
    logic               move;
    logic [ADDR_W-1:0]  move_addr;
    logic [VEC_W-1:0]   move_data;
    logic               acc_busy;

    // Pipeline has priority except in FORCE, where the starved line goes.
    assign grant_pipe = v_we && (slot_q != SLOT_FORCE);
    assign grant_pack = ((slot_q == SLOT_PEND) && !v_we) || (slot_q == SLOT_FORCE);
    assign v_stall    = v_we && (slot_q == SLOT_FORCE);
    // A slot being drained this cycle can be refilled in the same cycle, so
    // a line completing alongside the previous line's grant never stalls.
    assign slot_free  = (slot_q == SLOT_EMPTY) || grant_pack;
    assign wait_next  = wait_q + 1'b1;
    assign busy       = acc_busy || (slot_q != SLOT_EMPTY);

    vec_lane_acc u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .flush     (flush),
        .slot_free (slot_free),
        .s_stall   (s_stall),
        .move      (move),
        .move_addr (move_addr),
        .move_data (move_data),
        .acc_busy  (acc_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= SLOT_EMPTY;
            wait_q      <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            // RAM port: one registered write per grant. Address and data
            // hold their last value in idle cycles; only ram_we qualifies.
            ram_we <= grant_pipe || grant_pack;
            if (grant_pipe) begin
                ram_addr  <= v_addr;
                ram_wdata <= v_wdata;
            end else if (grant_pack) begin
                ram_addr  <= pend_addr_q;
                ram_wdata <= pend_data_q;
            end

            if (move) begin
                pend_addr_q <= move_addr;
                pend_data_q <= move_data;
            end

            case (slot_q)
                SLOT_EMPTY: begin
                    wait_q <= '0;
                    if (move) begin
                        slot_q <= SLOT_PEND;
                    end
                end
                SLOT_PEND: begin
                    if (grant_pack) begin
                        wait_q <= '0;
                        slot_q <= move ? SLOT_PEND : SLOT_EMPTY;
                    end else begin
                        wait_q <= wait_next;
                        if (wait_next >= STARVE_LIM) begin
                            slot_q <= SLOT_FORCE;
                        end
                    end
                end
                SLOT_FORCE: begin
                    wait_q <= '0;
                    slot_q <= move ? SLOT_PEND : SLOT_EMPTY;
                end
                default: begin
                    wait_q <= '0;
                    slot_q <= SLOT_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_pack_arbiter.sv
// Directed testbench for vec_pack_arbiter.
module tb_vec_pack_arbiter;

    logic         clk;
    logic         rst_n;
    logic         s_we;
    logic [15:0]  s_addr;
    logic [31:0]  s_data;
    logic         s_stall;
    logic         flush;
    logic         v_we;
    logic [15:0]  v_addr;
    logic [255:0] v_wdata;
    logic         v_stall;
    logic         ram_we;
    logic [15:0]  ram_addr;
    logic [255:0] ram_wdata;
    logic         busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int pidx         = 0;

    // Expected RAM writes, {addr, data}, in order of appearance.
    logic [271:0] exp_q[$];

    vec_pack_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .s_stall   (s_stall),
        .flush     (flush),
        .v_we      (v_we),
        .v_addr    (v_addr),
        .v_wdata   (v_wdata),
        .v_stall   (v_stall),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [271:0] got, input logic [271:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every RAM write must match the head of exp_q.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ram_unexpected_we", ram_we, 1'b0);
            end else begin
                check("ram_write", {ram_addr, ram_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- helpers / drivers ----------------
    function automatic logic [255:0] lane_w(input int k, input logic [31:0] w);
        return 256'(w) << (32 * k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus. The pipeline presents write number pidx; a
    // write taken without stall is expected on the RAM and advances pidx,
    // a stalled one is held and re-presented next cycle.
    task automatic cycle(input logic we, input logic [15:0] addr, input logic [31:0] data,
                         input logic fl, input logic vwe, input logic exp_ss, input logic exp_vs);
        s_we    = we;
        s_addr  = addr;
        s_data  = data;
        flush   = fl;
        v_we    = vwe;
        v_addr  = 16'h0100 + pidx[15:0];
        v_wdata = {8{16'hBE00, pidx[15:0]}};
        #1;
        check("s_stall", s_stall, exp_ss);
        check("v_stall", v_stall, exp_vs);
        if (vwe && !exp_vs) begin
            exp_q.push_back({v_addr, v_wdata});
            pidx++;
        end
        tick();
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] line;
        rst_n = 1'b0;
        s_we = 1'b0; s_addr = '0; s_data = '0; flush = 1'b0;
        v_we = 1'b0; v_addr = '0; v_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 16'h0);
        check("rst_ram_wdata", ram_wdata, 256'h0);
        check("rst_s_stall", s_stall, 1'b0);
        check("rst_v_stall", v_stall, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Full line: 0x10..0x17 = 1..8 -> vector 2.
        line = '0;
        for (int k = 0; k < 8; k++) line |= lane_w(k, 32'(k + 1));
        exp_q.push_back({16'h0002, line});
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 16'h0010 + 16'(k), 32'(k + 1), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("full_busy_pend", busy, 1'b1);
        idle();
        check("full_ram_we", ram_we, 1'b1);
        check("full_ram_addr", ram_addr, 16'h0002);
        check("full_ram_wdata", ram_wdata, line);
        idle();
        check("full_ram_we_off", ram_we, 1'b0);
        check("full_busy_done", busy, 1'b0);

        // Partial flush: lanes 1 and 3 of vector 4.
        line = lane_w(1, 32'hAA) | lane_w(3, 32'hBB);
        exp_q.push_back({16'h0004, line});
        cycle(1'b1, 16'h0021, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0023, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("flush_ram_addr", ram_addr, 16'h0004);
        check("flush_ram_wdata", ram_wdata, line);
        idle();

        // Flush with an empty accumulator does nothing.
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("noop_flush_busy", busy, 1'b0);
        idle();
        check("noop_flush_ram_we", ram_we, 1'b0);

        // Address change: 0x30 then 0x48 -> vector 6 written, vector 9 held.
        exp_q.push_back({16'h0006, lane_w(0, 32'h5)});
        cycle(1'b1, 16'h0030, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0048, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        check("chg_ram_addr", ram_addr, 16'h0006);
        check("chg_busy_acc", busy, 1'b1);
        exp_q.push_back({16'h0009, lane_w(0, 32'h6)});
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("chg_ram_addr2", ram_addr, 16'h0009);
        idle();

        // Starvation: write+flush to 0x50 while the pipeline writes every
        // cycle. Pipeline wins 4 PEND cycles, then FORCE stalls it once.
        cycle(1'b1, 16'h0050, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        exp_q.push_back({16'h000A, lane_w(0, 32'h77)});
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        check("starve_busy", busy, 1'b0);

        // Back-pressure: slot holds vector 0xC, pipeline busy, scalar write
        // to vector 0xE must stall until FORCE drains the slot.
        cycle(1'b1, 16'h0060, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0068, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'h0070, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        exp_q.push_back({16'h000C, lane_w(0, 32'h11)});
        cycle(1'b1, 16'h0070, 32'h33, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({16'h000D, lane_w(0, 32'h22)});
        idle();
        exp_q.push_back({16'h000E, lane_w(0, 32'h33)});
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("bp_ram_addr", ram_addr, 16'h000E);
        idle();
        check("bp_busy", busy, 1'b0);

        // Reset while a line is pending: no RAM write for it afterwards.
        cycle(1'b1, 16'h0080, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rstp_busy_before", busy, 1'b1);
        v_we = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstp_ram_we", ram_we, 1'b0);
        check("rstp_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        check("rstp_busy_after", busy, 1'b0);
        check("rstp_ram_we_after", ram_we, 1'b0);

        check("exp_q_drained", 272'(exp_q.size()), 272'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
